// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one host register-access command into the ordered
// START / WRITE / READ / STOP op-code stream for a byte-level I2C master and
// returns a single response carrying read data and a timeout error flag.
module i2c_txn_sequencer #(
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev_addr,
    input  logic [7:0]  cmd_reg_addr,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        i2c_enable,
    output logic        i2c_start,
    output logic        i2c_stop,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [7:0]  rx_data
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACCEPT,
        S_BYTE_WAIT,
        S_STOP_WAIT,
        S_DONE
    } state_e;

    // One master op: code bits plus the byte sent with START/WRITE.
    typedef struct packed {
        logic       start;
        logic       stop;
        logic [7:0] data;
    } op_t;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [6:0]         dev_q, dev_d;
    logic [7:0]         reg_q, reg_d;
    logic [1:0]         len_q, len_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               en_q, en_d;
    logic               start_q, start_d;
    logic               stop_q, stop_d;
    logic [7:0]         txd_q, txd_d;

    op_t                nxt_op;
    logic               timeout;
    logic               abort;
    logic               in_wait;
    logic               cur_is_read;
    logic               cur_is_stop;
    logic [1:0]         ridx;

    // Op list lookup: index -> code and byte for the latched command.
    function automatic op_t op_decode(
        input logic [IDX_W-1:0] idx,
        input logic             rw,
        input logic [6:0]       dev,
        input logic [7:0]       ra,
        input logic [1:0]       len,
        input logic [31:0]      wdata
    );
        op_t        op;
        logic [1:0] bsel;
        op   = '0;
        bsel = 2'(idx - 3'd2);
        if (idx == 3'd0) begin
            op.start = 1'b1;
            op.data  = {dev, 1'b0};
        end else if (idx == 3'd1) begin
            op.data = ra;
        end else if (!rw) begin
            if (idx <= 3'(len) + 3'd2) begin
                op.data = wdata[8*bsel +: 8];
            end else begin
                op.stop = 1'b1;
            end
        end else begin
            if (idx == 3'd2) begin
                op.start = 1'b1;
                op.data  = {dev, 1'b1};
            end else if (idx <= 3'(len) + 3'd3) begin
                op.start = 1'b1;
                op.stop  = 1'b1;
            end else begin
                op.stop = 1'b1;
            end
        end
        return op;
    endfunction

    assign nxt_op      = op_decode(idx_q + 3'd1, rw_q, dev_q, reg_q, len_q, wdata_q);
    assign timeout     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign in_wait     = (state_q == S_ARM) || (state_q == S_ACCEPT) ||
                         (state_q == S_BYTE_WAIT) || (state_q == S_STOP_WAIT);
    assign cur_is_read = start_q & stop_q;
    assign cur_is_stop = ~start_q & stop_q;
    assign ridx        = 2'(idx_q - 3'd3);

    // Next-state, op loading, read capture and wait-state timeout.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        en_d        = en_q;
        start_d     = start_q;
        stop_d      = stop_q;
        txd_d       = txd_q;
        abort       = 1'b0;
        cnt_d       = '0;

        case (state_q)
            S_IDLE: begin
                en_d    = 1'b0;
                start_d = 1'b0;
                stop_d  = 1'b0;
                txd_d   = 8'h00;
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    dev_d   = cmd_dev_addr;
                    reg_d   = cmd_reg_addr;
                    len_d   = cmd_len;
                    wdata_d = cmd_wdata;
                    rdata_d = 32'h0;
                    idx_d   = '0;
                    en_d    = 1'b1;
                    start_d = 1'b1;
                    stop_d  = 1'b0;
                    txd_d   = {cmd_dev_addr, 1'b0};
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (tx_ready) begin
                    state_d = S_ACCEPT;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            S_ACCEPT: begin
                if (!tx_ready) begin
                    en_d = 1'b0;
                    if (cur_is_stop) begin
                        start_d = 1'b0;
                        stop_d  = 1'b0;
                        txd_d   = 8'h00;
                        state_d = S_STOP_WAIT;
                    end else begin
                        state_d = S_BYTE_WAIT;
                    end
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            S_BYTE_WAIT: begin
                if (cur_is_read ? rx_done : tx_done) begin
                    if (cur_is_read) begin
                        rdata_d[8*ridx +: 8] = rx_data;
                    end
                    idx_d   = idx_q + 3'd1;
                    start_d = nxt_op.start;
                    stop_d  = nxt_op.stop;
                    txd_d   = nxt_op.data;
                    state_d = S_ARM;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            S_STOP_WAIT: begin
                if (tx_ready) begin
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            en_d        = 1'b0;
            start_d     = 1'b0;
            stop_d      = 1'b0;
            txd_d       = 8'h00;
            state_d     = S_IDLE;
        end

        if ((state_d == state_q) && in_wait) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            len_q       <= 2'd0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            en_q        <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            txd_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            en_q        <= en_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            txd_q       <= txd_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rdata_q;
    assign i2c_enable = en_q;
    assign i2c_start  = start_q;
    assign i2c_stop   = stop_q;
    assign tx_data    = txd_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a small behavioural I2C master.
module tb_i2c_txn_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [6:0]  cmd_dev_addr = 7'h00;
    logic [7:0]  cmd_reg_addr = 8'h00;
    logic [1:0]  cmd_len = 2'd0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        i2c_enable;
    logic        i2c_start;
    logic        i2c_stop;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_done;
    logic        rx_done;
    logic [7:0]  rx_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_txn_sequencer #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .busy(busy), .i2c_enable(i2c_enable), .i2c_start(i2c_start),
        .i2c_stop(i2c_stop), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_done(tx_done), .rx_done(rx_done), .rx_data(rx_data)
    );

    // Master model: idle -> hold (consume op) -> run -> done pulse -> gap -> hold.
    typedef enum logic [1:0] {M_IDLE, M_HOLD, M_RUN, M_GAP} m_state_e;
    m_state_e    m_st;
    logic [2:0]  m_cnt;
    logic        m_rd;
    logic        m_is_stop;
    logic [1:0]  m_ridx;
    logic        m_hang = 1'b0;
    logic [31:0] m_rbytes = 32'h0;
    logic [10:0] oplog[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st      <= M_IDLE;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
            rx_done   <= 1'b0;
            rx_data   <= 8'h00;
            m_cnt     <= 3'd0;
            m_rd      <= 1'b0;
            m_is_stop <= 1'b0;
            m_ridx    <= 2'd0;
        end else begin
            tx_done <= 1'b0;
            rx_done <= 1'b0;
            case (m_st)
                M_IDLE: begin
                    tx_ready <= 1'b1;
                    if (i2c_enable) begin
                        m_st   <= M_HOLD;
                        m_ridx <= 2'd0;
                    end
                end
                M_HOLD: begin
                    oplog.push_back({i2c_enable, i2c_start, i2c_stop, tx_data});
                    m_is_stop <= !i2c_start && i2c_stop;
                    m_rd      <= i2c_start && i2c_stop;
                    tx_ready  <= 1'b0;
                    m_cnt     <= 3'd3;
                    m_st      <= M_RUN;
                end
                M_RUN: begin
                    if (m_hang) begin
                        m_st <= M_RUN;
                    end else if (m_cnt != 3'd0) begin
                        m_cnt <= m_cnt - 3'd1;
                    end else if (m_is_stop) begin
                        tx_ready <= 1'b1;
                        m_st     <= M_IDLE;
                    end else begin
                        if (m_rd) begin
                            rx_done <= 1'b1;
                            rx_data <= m_rbytes[8*m_ridx +: 8];
                            m_ridx  <= m_ridx + 2'd1;
                        end else begin
                            tx_done <= 1'b1;
                        end
                        m_cnt <= 3'd2;
                        m_st  <= M_GAP;
                    end
                end
                default: begin
                    if (m_cnt != 3'd0) begin
                        m_cnt <= m_cnt - 3'd1;
                    end else begin
                        tx_ready <= 1'b1;
                        m_st     <= M_HOLD;
                    end
                end
            endcase
        end
    end

    typedef struct {
        logic          rw;
        logic [6:0]    dev;
        logic [7:0]    ra;
        logic [1:0]    len;
        logic [31:0]   wdata;
        logic [31:0]   rbytes;
        int            nops;
        logic [79:0]   ops;
        logic [31:0]   rdata;
    } vec_t;

    localparam logic [9:0] OPP = 10'h100;
    localparam logic [9:0] OPR = 10'h300;

    function automatic logic [9:0] op_s(input logic [7:0] d);
        return {2'b10, d};
    endfunction

    function automatic logic [9:0] op_w(input logic [7:0] d);
        return {2'b00, d};
    endfunction

    function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                                input logic [1:0] len, input logic [31:0] wdata,
                                input logic [31:0] rbytes, input int nops,
                                input logic [79:0] ops, input logic [31:0] rdata);
        vec_t v;
        v.rw = rw; v.dev = dev; v.ra = ra; v.len = len; v.wdata = wdata;
        v.rbytes = rbytes; v.nops = nops; v.ops = ops; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_master"}, 32'({i2c_enable, i2c_start, i2c_stop, tx_data}), 32'd0);
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_rw       = v.rw;
        cmd_dev_addr = v.dev;
        cmd_reg_addr = v.ra;
        cmd_len      = v.len;
        cmd_wdata    = v.wdata;
        cmd_valid    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          base;
        bit          got;
        logic        e;
        logic [31:0] rd;
        string       p;
        p = $sformatf("v%0d", id);
        got = 1'b0; e = 1'b0; rd = 32'h0;
        base = oplog.size();
        m_rbytes = v.rbytes;
        @(negedge clk);
        chk({p, "_ready"}, 32'(cmd_ready), 32'd1);
        drive_cmd(v);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({p, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 400 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                e   = rsp_err;
                rd  = rsp_rdata;
            end else begin
                @(negedge clk);
            end
        end
        chk({p, "_rsp_seen"}, 32'(got), 32'd1);
        chk({p, "_err"}, 32'(e), 32'd0);
        chk({p, "_rdata"}, rd, v.rdata);
        @(negedge clk);
        chk({p, "_one_pulse"}, 32'(rsp_valid), 32'd0);
        chk({p, "_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({p, "_nops"}, 32'(oplog.size() - base), 32'(v.nops));
        for (int i = 0; i < v.nops && base + i < oplog.size(); i++) begin
            chk($sformatf("%s_op%0d", p, i), 32'(oplog[base+i]),
                32'({i == 0, v.ops[10*i +: 10]}));
        end
    endtask

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n_acc, nrsp, acc1, acc2, rsp1, acc_c, rsp_c;
        bit changed, got;

        vecs[0] = mk(1'b0, 7'h48, 8'h01, 2'd0, 32'h000000A5, 32'h0, 4,
                     80'({OPP, op_w(8'hA5), op_w(8'h01), op_s(8'h90)}), 32'h0);
        vecs[1] = mk(1'b1, 7'h48, 8'h00, 2'd1, 32'h0, 32'h00003412, 6,
                     80'({OPP, OPR, OPR, op_s(8'h91), op_w(8'h00), op_s(8'h90)}), 32'h00003412);
        vecs[2] = mk(1'b0, 7'h2C, 8'h10, 2'd3, 32'hDDCCBBAA, 32'h0, 7,
                     80'({OPP, op_w(8'hDD), op_w(8'hCC), op_w(8'hBB), op_w(8'hAA),
                          op_w(8'h10), op_s(8'h58)}), 32'h0);
        vecs[3] = mk(1'b1, 7'h7F, 8'hFF, 2'd3, 32'h0, 32'h5AFE8001, 8,
                     80'({OPP, OPR, OPR, OPR, OPR, op_s(8'hFF), op_w(8'hFF), op_s(8'hFE)}),
                     32'h5AFE8001);
        vecs[4] = mk(1'b1, 7'h00, 8'h33, 2'd0, 32'h0, 32'h000000C3, 5,
                     80'({OPP, OPR, op_s(8'h01), op_w(8'h33), op_s(8'h00)}), 32'h000000C3);

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], k);
        end

        // Master stalls after consuming START: abort 100 cycles into BYTE_WAIT.
        m_hang = 1'b1;
        base = oplog.size();
        @(negedge clk);
        drive_cmd(vecs[0]);
        acc_c = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        rsp_c = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (rsp_valid) begin
                got   = 1'b1;
                rsp_c = cyc;
                chk("to_err", 32'(rsp_err), 32'd1);
                chk("to_master_zero", 32'({i2c_enable, i2c_start, i2c_stop, tx_data}), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        chk("to_seen", 32'(got), 32'd1);
        // BYTE_WAIT is entered 3 edges after acceptance; abort lands 100 cycles later.
        chk("to_latency", 32'(rsp_c - acc_c), 32'd103);
        chk("to_first_op", 32'(oplog[base]), 32'({3'b110, 8'h90}));
        @(negedge clk);
        chk("to_ready_next", 32'(cmd_ready), 32'd1);
        chk("to_one_pulse", 32'(rsp_valid), 32'd0);
        m_hang = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // cmd_valid held high with fields changed mid-transaction.
        base = oplog.size();
        n_acc = 0; nrsp = 0; acc1 = 0; acc2 = 0; rsp1 = 0; changed = 1'b0;
        @(negedge clk);
        drive_cmd(mk(1'b0, 7'h11, 8'h22, 2'd0, 32'h00000033, 32'h0, 0, 80'h0, 32'h0));
        for (int i = 0; i < 600 && nrsp < 2; i++) begin
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                if (n_acc == 1) acc1 = cyc;
                else acc2 = cyc;
            end
            if (rsp_valid) begin
                nrsp++;
                if (nrsp == 1) rsp1 = cyc;
            end
            if (n_acc == 1 && !changed && cyc > acc1) begin
                drive_cmd(mk(1'b0, 7'h05, 8'h06, 2'd1, 32'h00000807, 32'h0, 0, 80'h0, 32'h0));
                changed = 1'b1;
            end
            if (n_acc == 2 && cyc > acc2) cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("held_rsp_count", 32'(nrsp), 32'd2);
        chk("held_accepts", 32'(n_acc), 32'd2);
        chk("held_b2b", 32'(acc2 - rsp1), 32'd1);
        chk("held_nops", 32'(oplog.size() - base), 32'd9);
        if (oplog.size() >= base + 9) begin
            chk("held_a_data", 32'(oplog[base+2]), 32'({3'b000, 8'h33}));
            chk("held_b_start", 32'(oplog[base+4]), 32'({3'b110, 8'h0A}));
            chk("held_b_data0", 32'(oplog[base+6]), 32'({3'b000, 8'h07}));
            chk("held_b_data1", 32'(oplog[base+7]), 32'({3'b000, 8'h08}));
        end

        // Reset during a READ byte: immediate reset values, no response.
        base = oplog.size();
        m_rbytes = 32'h44332211;
        @(negedge clk);
        drive_cmd(mk(1'b1, 7'h48, 8'h00, 2'd3, 32'h0, 32'h0, 0, 80'h0, 32'h0));
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 300 && oplog.size() < base + 5; i++) @(negedge clk);
        chk("rst_reached_read", 32'(oplog.size() >= base + 5), 32'd1);
        @(negedge clk);
        chk("rst_partial", rsp_rdata, 32'h00000011);
        chk("rst_in_read", 32'({i2c_start, i2c_stop}), 32'd3);
        reset = 1'b1;
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("rst_no_rsp", 32'(nrsp), 32'd0);
        run_vec(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
